// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared encodings for the multi-cycle RISC-V control path
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BEQ       = 4'd10,
    S_ERROR     = 4'd11
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [6:0] F7_ADD  = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // Shared with the ALU; must match its decode.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'b00,
    ALU_CLS_SUB   = 2'b01,
    ALU_CLS_FUNCT = 2'b10
  } alu_class_e;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_REG    = 2'b10;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MDR        = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps the FSM's ALU class and funct7[5] to an ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_class_e  alu_class_i,
  input  logic        funct7_5_i,
  output logic [3:0]  alu_operation_o
);

  always_comb begin
    alu_operation_o = ALU_ADD;
    case (alu_class_i)
      ALU_CLS_SUB:   alu_operation_o = ALU_SUB;
      ALU_CLS_FUNCT: alu_operation_o = funct7_5_i ? ALU_SUB : ALU_ADD;
      default:       alu_operation_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_control
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode_i,
  input  logic [2:0] Funct3_i,
  input  logic [6:0] Funct7_i,
  input  logic       Zero_i,
  output logic       PC_Write_o,
  output logic       IorD_o,
  output logic       IR_Write_o,
  output logic       Mem_Write_o,
  output logic       Reg_Write_o,
  output logic [1:0] ALU_Src_A_o,
  output logic [1:0] ALU_Src_B_o,
  output logic [1:0] Result_Src_o,
  output logic [3:0] ALU_Operation_o,
  output logic       Illegal_o
);

  state_e     state_q, state_d;
  alu_class_e alu_class;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    alu_class    = ALU_CLS_ADD;
    PC_Write_o   = 1'b0;
    IorD_o       = 1'b0;
    IR_Write_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    Reg_Write_o  = 1'b0;
    ALU_Src_A_o  = SRC_A_PC;
    ALU_Src_B_o  = SRC_B_REG;
    Result_Src_o = RES_ALU_OUT;
    Illegal_o    = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        IR_Write_o   = 1'b1;
        PC_Write_o   = 1'b1;
        ALU_Src_B_o  = SRC_B_FOUR;
        Result_Src_o = RES_ALU_RESULT;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BEQ can load it from ALU_Out.
        ALU_Src_A_o = SRC_A_OLD_PC;
        ALU_Src_B_o = SRC_B_IMM;
        if ((Opcode_i == OP_LOAD || Opcode_i == OP_STORE) && Funct3_i == F3_WORD)
          state_d = S_MEM_ADR;
        else if (Opcode_i == OP_R && Funct3_i == F3_ADD &&
                 (Funct7_i == F7_ADD || Funct7_i == F7_SUB))
          state_d = S_EXEC_R;
        else if (Opcode_i == OP_I && Funct3_i == F3_ADD)
          state_d = S_EXEC_I;
        else if (Opcode_i == OP_BRANCH && Funct3_i == F3_BEQ)
          state_d = S_BEQ;
        else
          state_d = S_ERROR;
      end
      S_MEM_ADR: begin
        ALU_Src_A_o = SRC_A_REG;
        ALU_Src_B_o = SRC_B_IMM;
        state_d     = (Opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        IorD_o  = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        Result_Src_o = RES_MDR;
        Reg_Write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WRITE: begin
        IorD_o      = 1'b1;
        Mem_Write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        ALU_Src_A_o = SRC_A_REG;
        alu_class   = ALU_CLS_FUNCT;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = SRC_A_REG;
        ALU_Src_B_o = SRC_B_IMM;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        Reg_Write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        // Only Mealy output: the PC takes ALU_Out when the compare is equal.
        ALU_Src_A_o = SRC_A_REG;
        alu_class   = ALU_CLS_SUB;
        PC_Write_o  = Zero_i;
        state_d     = S_FETCH;
      end
      S_ERROR: Illegal_o = 1'b1;
      default: state_d = S_ERROR;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class_i     (alu_class),
    .funct7_5_i      (Funct7_i[5]),
    .alu_operation_o (ALU_Operation_o)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against a per-instruction output model
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode_i = '0;
  logic [2:0] Funct3_i = '0;
  logic [6:0] Funct7_i = '0;
  logic       Zero_i = 1'b0;
  logic       PC_Write_o, IorD_o, IR_Write_o, Mem_Write_o, Reg_Write_o, Illegal_o;
  logic [1:0] ALU_Src_A_o, ALU_Src_B_o, Result_Src_o;
  logic [3:0] ALU_Operation_o;

  multicycle_control dut (
    .clk             (clk),
    .reset           (reset),
    .Opcode_i        (Opcode_i),
    .Funct3_i        (Funct3_i),
    .Funct7_i        (Funct7_i),
    .Zero_i          (Zero_i),
    .PC_Write_o      (PC_Write_o),
    .IorD_o          (IorD_o),
    .IR_Write_o      (IR_Write_o),
    .Mem_Write_o     (Mem_Write_o),
    .Reg_Write_o     (Reg_Write_o),
    .ALU_Src_A_o     (ALU_Src_A_o),
    .ALU_Src_B_o     (ALU_Src_B_o),
    .Result_Src_o    (Result_Src_o),
    .ALU_Operation_o (ALU_Operation_o),
    .Illegal_o       (Illegal_o)
  );

  always #5 clk = ~clk;

  // Packed view: [15]pcw [14]iord [13]irw [12]mw [11]rw [10:9]A [8:7]B [6:5]res [4:1]op [0]ill
  logic [15:0] obs;
  assign obs = {PC_Write_o, IorD_o, IR_Write_o, Mem_Write_o, Reg_Write_o,
                ALU_Src_A_o, ALU_Src_B_o, Result_Src_o, ALU_Operation_o, Illegal_o};

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic        pcw2_q[$];

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  function automatic logic [15:0] mk(input logic pcw, input logic iord, input logic irw,
                                     input logic mw, input logic rw, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] rs,
                                     input logic [3:0] aop, input logic ill);
    return {pcw, iord, irw, mw, rw, a, b, rs, aop, ill};
  endfunction

  // Expected per-cycle outputs of one instruction, starting at its FETCH cycle.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic zero, input int err_len);
    exp_q.delete();
    exp_q.push_back(mk(H, L, H, L, L, 2'b00, 2'b10, 2'b10, 4'b0000, L));
    exp_q.push_back(mk(L, L, L, L, L, 2'b01, 2'b01, 2'b00, 4'b0000, L));
    if ((op == 7'b0000011 || op == 7'b0100011) && f3 == 3'b010) begin
      exp_q.push_back(mk(L, L, L, L, L, 2'b10, 2'b01, 2'b00, 4'b0000, L));
      if (op == 7'b0000011) begin
        exp_q.push_back(mk(L, H, L, L, L, 2'b00, 2'b00, 2'b00, 4'b0000, L));
        exp_q.push_back(mk(L, L, L, L, H, 2'b00, 2'b00, 2'b01, 4'b0000, L));
      end else begin
        exp_q.push_back(mk(L, H, L, H, L, 2'b00, 2'b00, 2'b00, 4'b0000, L));
      end
    end else if (op == 7'b0110011 && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
      exp_q.push_back(mk(L, L, L, L, L, 2'b10, 2'b00, 2'b00,
                         (f7 == 7'b0100000) ? 4'b0001 : 4'b0000, L));
      exp_q.push_back(mk(L, L, L, L, H, 2'b00, 2'b00, 2'b00, 4'b0000, L));
    end else if (op == 7'b0010011 && f3 == 3'b000) begin
      exp_q.push_back(mk(L, L, L, L, L, 2'b10, 2'b01, 2'b00, 4'b0000, L));
      exp_q.push_back(mk(L, L, L, L, H, 2'b00, 2'b00, 2'b00, 4'b0000, L));
    end else if (op == 7'b1100011 && f3 == 3'b000) begin
      exp_q.push_back(mk(zero, L, L, L, L, 2'b10, 2'b00, 2'b00, 4'b0001, L));
    end else begin
      repeat (err_len) exp_q.push_back(mk(L, L, L, L, L, 2'b00, 2'b00, 2'b00, 4'b0000, H));
    end
  endtask

  // Stimulus only: junk fields during FETCH, real fields afterwards, Zero flipped late each cycle.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic zero, input int ncyc);
    obs_q.delete();
    pcw2_q.delete();
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        Opcode_i = 7'($urandom);
        Funct3_i = 3'($urandom);
        Funct7_i = 7'($urandom);
      end else begin
        Opcode_i = op;
        Funct3_i = f3;
        Funct7_i = f7;
      end
      Zero_i = (k == 2) ? zero : 1'($urandom);
      @(negedge clk);
      obs_q.push_back(obs);
      #2 Zero_i = ~Zero_i;
      #1 pcw2_q.push_back(PC_Write_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_hold outputs got %h want 0000", obs);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL init_outputs got %h want 0000", obs);
    end
  endtask

  task automatic test_r_type();
    int rw_cnt;
    model_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, 0);
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0, exp_q.size());
    rw_cnt = 0;
    foreach (exp_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL sub cycle %0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
      rw_cnt += int'(obs_q[k][11]);
    end
    n_cmp++;
    if (obs_q[2][4:1] !== 4'b0001) begin
      n_fail++;
      $display("FAIL sub_exec_aluop got %b want 0001", obs_q[2][4:1]);
    end
    n_cmp++;
    if (rw_cnt !== 1) begin
      n_fail++;
      $display("FAIL sub_regwrite_count got %0d want 1", rw_cnt);
    end
  endtask

  task automatic test_lw();
    int mw_cnt;
    model_instr(7'b0000011, 3'b010, 7'($urandom), 1'b0, 0);
    run_instr(7'b0000011, 3'b010, 7'($urandom), 1'b0, 5);
    mw_cnt = 0;
    foreach (exp_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL lw cycle %0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
      mw_cnt += int'(obs_q[k][12]);
    end
    n_cmp++;
    if (obs_q[3][14] !== 1'b1 || obs_q[4][6:5] !== 2'b01 || obs_q[4][11] !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_read_wb got iord=%b res=%b rw=%b want 1 01 1",
               obs_q[3][14], obs_q[4][6:5], obs_q[4][11]);
    end
    n_cmp++;
    if (mw_cnt !== 0) begin
      n_fail++;
      $display("FAIL lw_memwrite_count got %0d want 0", mw_cnt);
    end
  endtask

  task automatic test_sw();
    int mw_cnt, rw_cnt;
    model_instr(7'b0100011, 3'b010, 7'($urandom), 1'b0, 0);
    run_instr(7'b0100011, 3'b010, 7'($urandom), 1'b0, 4);
    mw_cnt = 0;
    rw_cnt = 0;
    foreach (exp_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL sw cycle %0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
      mw_cnt += int'(obs_q[k][12]);
      rw_cnt += int'(obs_q[k][11]);
    end
    n_cmp++;
    if (mw_cnt !== 1 || obs_q[3][12] !== 1'b1 || rw_cnt !== 0) begin
      n_fail++;
      $display("FAIL sw_strobes got mw=%0d mw@4=%b rw=%0d want 1 1 0", mw_cnt, obs_q[3][12], rw_cnt);
    end
  endtask

  task automatic test_beq();
    logic z;
    for (int r = 0; r < 2; r++) begin
      z = (r == 0);
      model_instr(7'b1100011, 3'b000, 7'($urandom), z, 0);
      run_instr(7'b1100011, 3'b000, 7'($urandom), z, 3);
      foreach (exp_q[k]) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL beq z=%b cycle %0d got %h want %h", z, k, obs_q[k], exp_q[k]);
        end
      end
      n_cmp++;
      if (obs_q[2][15] !== z || pcw2_q[2] !== ~z) begin
        n_fail++;
        $display("FAIL beq_pcwrite z=%b got %b then %b want %b then %b", z, obs_q[2][15], pcw2_q[2], z, ~z);
      end
    end
  endtask

  task automatic test_illegal();
    model_instr(7'b1111111, 3'($urandom), 7'($urandom), 1'b0, 20);
    run_instr(7'b1111111, 3'($urandom), 7'($urandom), 1'b0, 22);
    foreach (exp_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL illegal cycle %0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL illegal_reset got %h want 0000", obs);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic       z;
    for (int n = 0; n < 150; n++) begin
      f7 = 7'($urandom);
      case ($urandom_range(0, 5))
        0: begin op = 7'b0000011; f3 = 3'b010; end
        1: begin op = 7'b0100011; f3 = 3'b010; end
        2: begin op = 7'b0110011; f3 = 3'b000; f7 = $urandom_range(0, 1) ? 7'b0100000 : 7'b0000000; end
        3: begin op = 7'b0010011; f3 = 3'b000; end
        4: begin op = 7'b1100011; f3 = 3'b000; end
        default: begin op = 7'($urandom); f3 = 3'($urandom); end
      endcase
      if ($urandom_range(0, 7) == 0) op = op ^ 7'(32'd1 << $urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) f3 = f3 ^ 3'(32'd1 << $urandom_range(0, 2));
      z = 1'($urandom);
      model_instr(op, f3, f7, z, 3);
      run_instr(op, f3, f7, z, exp_q.size());
      foreach (exp_q[k]) begin
        n_cmp++;
        if (obs_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL random #%0d op=%b f3=%b f7=%b cycle %0d got %h want %h",
                   n, op, f3, f7, k, obs_q[k], exp_q[k]);
        end
      end
      if (exp_q[exp_q.size() - 1][0]) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    model_instr(7'b0100011, 3'b010, 7'($urandom), 1'b0, 0);
    run_instr(7'b0100011, 3'b010, 7'($urandom), 1'b0, 3);
    foreach (obs_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL async_pre cycle %0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (Mem_Write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_memwrite_before got %b want 1", Mem_Write_o);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (Mem_Write_o !== 1'b0 || obs !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_drop got mw=%b outputs=%h want 0 0000", Mem_Write_o, obs);
    end
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 16'h0000) begin
        n_fail++;
        $display("FAIL async_hold got %h want 0000", obs);
      end
    end
    reset = 1'b0;
    model_instr(7'b0010011, 3'b000, 7'($urandom), 1'b0, 0);
    run_instr(7'b0010011, 3'b000, 7'($urandom), 1'b0, 4);
    foreach (exp_q[k]) begin
      n_cmp++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL async_recover cycle %0d got %h want %h", k, obs_q[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
